// File: rtl/circle_capture_multi_pkg.sv
// Shared definitions for the triggered capture buffer array: channel states
// and trigger-mode codes.
package circle_capture_multi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_ARMED,
      ST_POST,
      ST_AVAIL
   } cap_state_t;

   localparam logic [1:0] TM_EXT    = 2'b00;
   localparam logic [1:0] TM_GE     = 2'b01;
   localparam logic [1:0] TM_LE     = 2'b10;
   localparam logic [1:0] TM_EXT_GE = 2'b11;

endpackage

// File: rtl/circle_capture_chan.sv
// One capture channel: arm/pre/armed/post/avail FSM, ring write pointer,
// read pointer with rewind, sticky over-read flag, simple dual-port RAM.
module circle_capture_chan
   import circle_capture_multi_pkg::*;
#(
   parameter int DWIDTH = 16,
   parameter int BUF_AW = 10
) (
   input  logic              dsp_clk,
   input  logic              reset_n,
   input  logic [DWIDTH-1:0] wave,
   input  logic              wave_strobe,
   input  logic              arm,
   input  logic              trig_ext,
   input  logic [1:0]        trig_mode,
   input  logic [DWIDTH-1:0] threshold,
   input  logic [BUF_AW-1:0] pre_count,
   input  logic [BUF_AW-1:0] post_count,
   input  logic              stb_r,
   input  logic              rewind,
   output logic [DWIDTH-1:0] wave_result,
   output logic              result_valid,
   output logic              wave_available,
   output logic [BUF_AW-1:0] trig_addr,
   output logic              read_err
);

   localparam int LW = BUF_AW + 2;

   logic [DWIDTH-1:0] mem [2**BUF_AW];
   cap_state_t        state;
   logic [BUF_AW-1:0] wptr, rptr, start, pre_l, post_l, cnt;
   logic [LW-1:0]     len, rd_idx, idx_eff;
   logic              pend, hit, ext_mode, wr_en, rd_en;
   logic [BUF_AW-1:0] raddr;

   assign ext_mode = (trig_mode == TM_EXT) || (trig_mode == TM_EXT_GE);

   always_comb begin
      hit = 1'b0;
      case (trig_mode)
         TM_EXT:  hit = pend;
         TM_GE:   hit = $signed(wave) >= $signed(threshold);
         TM_LE:   hit = $signed(wave) <= $signed(threshold);
         default: hit = pend || ($signed(wave) >= $signed(threshold));
      endcase
   end

   assign wr_en   = wave_strobe && !arm &&
                    (state == ST_PRE || state == ST_ARMED || state == ST_POST);
   assign rd_en   = stb_r && !arm && (state == ST_AVAIL);
   // rewind takes effect before a same-cycle read
   assign raddr   = rewind ? start : rptr;
   assign idx_eff = rewind ? '0 : rd_idx;
   assign wave_available = (state == ST_AVAIL);

   always_ff @(posedge dsp_clk) begin
      if (wr_en) mem[wptr] <= wave;
   end

   always_ff @(posedge dsp_clk or negedge reset_n) begin
      if (!reset_n)   wave_result <= '0;
      else if (rd_en) wave_result <= mem[raddr];
   end

   always_ff @(posedge dsp_clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         wptr         <= '0;
         rptr         <= '0;
         start        <= '0;
         pre_l        <= '0;
         post_l       <= '0;
         cnt          <= '0;
         len          <= '0;
         rd_idx       <= '0;
         pend         <= 1'b0;
         trig_addr    <= '0;
         read_err     <= 1'b0;
         result_valid <= 1'b0;
      end else begin
         result_valid <= rd_en;
         if (arm) begin
            state    <= (pre_count == '0) ? ST_ARMED : ST_PRE;
            wptr     <= '0;
            cnt      <= '0;
            pend     <= 1'b0;
            read_err <= 1'b0;
            pre_l    <= pre_count;
            post_l   <= post_count;
            len      <= LW'(pre_count) + LW'(post_count) + LW'(1);
         end else begin
            case (state)
               ST_PRE: if (wave_strobe) begin
                  wptr <= wptr + 1'b1;
                  if (cnt == pre_l - 1'b1) begin
                     state <= ST_ARMED;
                     cnt   <= '0;
                  end else cnt <= cnt + 1'b1;
               end
               ST_ARMED: begin
                  if (trig_ext && ext_mode) pend <= 1'b1;
                  if (wave_strobe) begin
                     wptr <= wptr + 1'b1;
                     if (hit) begin
                        trig_addr <= wptr;
                        pend      <= 1'b0;
                        start     <= wptr - pre_l;
                        rptr      <= wptr - pre_l;
                        rd_idx    <= '0;
                        cnt       <= '0;
                        state     <= (post_l == '0) ? ST_AVAIL : ST_POST;
                     end
                  end
               end
               ST_POST: if (wave_strobe) begin
                  wptr <= wptr + 1'b1;
                  if (cnt == post_l - 1'b1) state <= ST_AVAIL;
                  else cnt <= cnt + 1'b1;
               end
               ST_AVAIL: begin
                  if (stb_r) begin
                     rptr <= raddr + 1'b1;
                     // index saturates at len; the error flag carries the rest
                     if (idx_eff >= len) begin
                        read_err <= 1'b1;
                        rd_idx   <= idx_eff;
                     end else rd_idx <= idx_eff + 1'b1;
                  end else if (rewind) begin
                     rptr   <= start;
                     rd_idx <= '0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: rtl/circle_capture_multi.sv
// Array of independent triggered capture channels sharing one clock, threshold
// and pre/post depth controls.
module circle_capture_multi #(
   parameter int CHANS  = 8,
   parameter int DWIDTH = 16,
   parameter int BUF_AW = 10
) (
   input  logic                    dsp_clk,
   input  logic                    reset_n,
   input  logic [DWIDTH*CHANS-1:0] wave,
   input  logic [CHANS-1:0]        wave_strobe,
   input  logic [CHANS-1:0]        arm,
   input  logic [CHANS-1:0]        trig_ext,
   input  logic [2*CHANS-1:0]      trig_mode,
   input  logic [DWIDTH-1:0]       threshold,
   input  logic [BUF_AW-1:0]       pre_count,
   input  logic [BUF_AW-1:0]       post_count,
   input  logic [CHANS-1:0]        stb_r,
   input  logic [CHANS-1:0]        rewind,
   output logic [DWIDTH*CHANS-1:0] wave_result,
   output logic [CHANS-1:0]        result_valid,
   output logic [CHANS-1:0]        wave_available,
   output logic [BUF_AW*CHANS-1:0] trig_addr,
   output logic [CHANS-1:0]        read_err
);

   localparam int WID_CHANS = (CHANS > 1) ? $clog2(CHANS) : 1;

   // walk the full channel-index space; indices beyond CHANS are left empty
   for (genvar ch = 0; ch < (1 << WID_CHANS); ch++) begin : g_chan
      if (ch < CHANS) begin : g_inst
         circle_capture_chan #(.DWIDTH(DWIDTH), .BUF_AW(BUF_AW)) u_chan (
            .dsp_clk       (dsp_clk),
            .reset_n       (reset_n),
            .wave          (wave[DWIDTH*ch +: DWIDTH]),
            .wave_strobe   (wave_strobe[ch]),
            .arm           (arm[ch]),
            .trig_ext      (trig_ext[ch]),
            .trig_mode     (trig_mode[2*ch +: 2]),
            .threshold     (threshold),
            .pre_count     (pre_count),
            .post_count    (post_count),
            .stb_r         (stb_r[ch]),
            .rewind        (rewind[ch]),
            .wave_result   (wave_result[DWIDTH*ch +: DWIDTH]),
            .result_valid  (result_valid[ch]),
            .wave_available(wave_available[ch]),
            .trig_addr     (trig_addr[BUF_AW*ch +: BUF_AW]),
            .read_err      (read_err[ch])
         );
      end
   end

endmodule

// File: tb/tb_circle_capture_multi.sv
// Directed bench for circle_capture_multi (2 channels, 16-deep buffers) with a
// sample-count model checked every cycle plus literal expectations.
module tb_circle_capture_multi;
   localparam int CH = 2, DW = 16, AW = 4, DEPTH = 16;

   logic            dsp_clk = 0, reset_n = 0;
   logic [DW*CH-1:0] wave = '0;
   logic [CH-1:0]   wave_strobe = '0, arm = '0, trig_ext = '0, stb_r = '0, rewind = '0;
   logic [2*CH-1:0] trig_mode = '0;
   logic [DW-1:0]   threshold = '0;
   logic [AW-1:0]   pre_count = '0, post_count = '0;
   logic [DW*CH-1:0] wave_result;
   logic [CH-1:0]   result_valid, wave_available, read_err;
   logic [AW*CH-1:0] trig_addr;

   int checks = 0, failures = 0;
   bit chk_en = 0;

   circle_capture_multi #(.CHANS(CH), .DWIDTH(DW), .BUF_AW(AW)) dut (
      .dsp_clk(dsp_clk), .reset_n(reset_n), .wave(wave), .wave_strobe(wave_strobe),
      .arm(arm), .trig_ext(trig_ext), .trig_mode(trig_mode), .threshold(threshold),
      .pre_count(pre_count), .post_count(post_count), .stb_r(stb_r), .rewind(rewind),
      .wave_result(wave_result), .result_valid(result_valid),
      .wave_available(wave_available), .trig_addr(trig_addr), .read_err(read_err));

   always #5 dsp_clk = ~dsp_clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   // model: each channel tracks samples since arm; sample n lives at address n mod DEPTH
   bit  m_active [CH], m_done [CH], m_pend [CH];
   int  m_n [CH], m_trig [CH], m_pre [CH], m_post [CH], m_start [CH], m_rk [CH];
   int  m_mem [CH][DEPTH];
   bit  m_mv [CH][DEPTH];
   bit  e_avail [CH], e_err [CH], e_rv [CH], e_res_ok [CH];
   int  e_taddr [CH], e_res [CH];

   always @(posedge dsp_clk or negedge reset_n) begin
      for (int c = 0; c < CH; c++) begin
         int s, mode, old_pend;
         bit in_armed, hit;
         if (!reset_n) begin
            m_active[c] = 0; m_done[c] = 0; m_pend[c] = 0;
            e_avail[c] = 0; e_err[c] = 0; e_rv[c] = 0; e_taddr[c] = 0;
            e_res[c] = 0; e_res_ok[c] = 1;
         end else begin
            e_rv[c] = 0;
            s    = int'($signed(wave[DW*c +: DW]));
            mode = int'(trig_mode[2*c +: 2]);
            if (arm[c]) begin
               m_active[c] = 1; m_done[c] = 0; m_pend[c] = 0; m_n[c] = 0; m_trig[c] = -1;
               m_pre[c] = int'(pre_count); m_post[c] = int'(post_count);
               e_err[c] = 0; e_avail[c] = 0;
            end else if (m_done[c]) begin
               if (rewind[c]) m_rk[c] = 0;
               if (stb_r[c]) begin
                  int a;
                  a = (m_start[c] + m_rk[c]) % DEPTH;
                  e_rv[c] = 1;
                  e_res[c] = m_mem[c][a];
                  e_res_ok[c] = m_mv[c][a];
                  if (m_rk[c] >= m_pre[c] + m_post[c] + 1) e_err[c] = 1;
                  m_rk[c]++;
               end
            end else if (m_active[c]) begin
               in_armed = (m_n[c] >= m_pre[c]) && (m_trig[c] < 0);
               old_pend = m_pend[c];
               if (in_armed && trig_ext[c] && (mode == 0 || mode == 3)) m_pend[c] = 1;
               if (wave_strobe[c]) begin
                  m_mem[c][m_n[c] % DEPTH] = s;
                  m_mv[c][m_n[c] % DEPTH]  = 1;
                  if (in_armed) begin
                     int t;
                     t = int'($signed(threshold));
                     case (mode)
                        0: hit = old_pend != 0;
                        1: hit = s >= t;
                        2: hit = s <= t;
                        default: hit = (old_pend != 0) || (s >= t);
                     endcase
                     if (hit) begin
                        m_trig[c] = m_n[c];
                        e_taddr[c] = m_n[c] % DEPTH;
                        m_pend[c] = 0;
                     end
                  end
                  m_n[c]++;
                  if (m_trig[c] >= 0 && m_n[c] - 1 == m_trig[c] + m_post[c]) begin
                     m_done[c] = 1; e_avail[c] = 1; m_rk[c] = 0;
                     m_start[c] = ((m_trig[c] - m_pre[c]) % DEPTH + DEPTH) % DEPTH;
                  end
               end
            end
         end
      end
   end

   always @(negedge dsp_clk) begin
      if (chk_en) begin
         for (int c = 0; c < CH; c++) begin
            chk($sformatf("mdl_avail[%0d]", c), int'(wave_available[c]), int'(e_avail[c]));
            chk($sformatf("mdl_taddr[%0d]", c), int'(trig_addr[AW*c +: AW]), e_taddr[c]);
            chk($sformatf("mdl_err[%0d]", c), int'(read_err[c]), int'(e_err[c]));
            chk($sformatf("mdl_rv[%0d]", c), int'(result_valid[c]), int'(e_rv[c]));
            if (e_res_ok[c])
               chk($sformatf("mdl_res[%0d]", c), int'($signed(wave_result[DW*c +: DW])), e_res[c]);
         end
      end
   end

   task automatic strobe(input logic [CH-1:0] m, input int v);
      @(negedge dsp_clk);
      for (int c = 0; c < CH; c++) wave[DW*c +: DW] = DW'(v);
      wave_strobe = m;
      @(negedge dsp_clk);
      wave_strobe = '0;
   endtask

   task automatic pulse_arm(input logic [CH-1:0] m);
      @(negedge dsp_clk); arm = m;
      @(negedge dsp_clk); arm = '0;
   endtask

   task automatic pulse_ext(input logic [CH-1:0] m);
      @(negedge dsp_clk); trig_ext = m;
      @(negedge dsp_clk); trig_ext = '0;
   endtask

   task automatic rd(input logic [CH-1:0] m, input logic [CH-1:0] rw);
      @(negedge dsp_clk); stb_r = m; rewind = rw;
      @(negedge dsp_clk); stb_r = '0; rewind = '0;
   endtask

   function automatic int res0();
      return int'($signed(wave_result[DW-1:0]));
   endfunction

   initial begin
      repeat (3) @(negedge dsp_clk);
      chk_en = 1;
      @(negedge dsp_clk);
      chk("reset_avail", int'(wave_available), 0);
      chk("reset_rv", int'(result_valid), 0);
      chk("reset_res", int'(wave_result), 0);
      reset_n = 1;

      // external trigger on ch0; ch1 armed but never triggered
      pre_count = 3; post_count = 4; trig_mode = 4'b0000;
      pulse_arm(2'b11);
      for (int v = 1; v <= 10; v++) strobe(2'b11, v);
      pulse_ext(2'b01);
      for (int v = 11; v <= 15; v++) strobe(2'b11, v);
      chk("ext_avail", int'(wave_available), 1);
      chk("ext_taddr", int'(trig_addr[AW-1:0]), 10);
      for (int i = 0; i < 8; i++) begin
         rd(2'b01, 2'b00);
         chk("ext_read", res0(), 8 + i);
      end
      chk("ext_err_before", int'(read_err[0]), 0);
      rd(2'b01, 2'b00);
      chk("ext_err_after", int'(read_err[0]), 1);
      rd(2'b10, 2'b00);
      chk("ch1_no_rv", int'(result_valid[1]), 0);
      rd(2'b01, 2'b01);
      chk("rewind_read", res0(), 8);
      chk("err_sticky", int'(read_err[0]), 1);

      // re-arm from AVAIL, trigger wraps the ring
      pre_count = 3; post_count = 2;
      pulse_arm(2'b01);
      chk("rearm_avail_low", int'(wave_available[0]), 0);
      chk("rearm_err_clr", int'(read_err[0]), 0);
      for (int v = 1; v <= 17; v++) strobe(2'b01, v);
      pulse_ext(2'b01);
      for (int v = 18; v <= 20; v++) strobe(2'b01, v);
      chk("wrap_taddr", int'(trig_addr[AW-1:0]), 1);
      chk("wrap_avail", int'(wave_available[0]), 1);
      for (int i = 0; i < 6; i++) begin
         rd(2'b01, 2'b00);
         chk("wrap_read", res0(), 15 + i);
      end

      // threshold >=, zero pre/post
      pre_count = 0; post_count = 0; trig_mode = 4'b0001; threshold = 16'd100;
      pulse_arm(2'b01);
      for (int i = 0; i <= 12; i++) strobe(2'b01, 10 * i);
      chk("ge_taddr", int'(trig_addr[AW-1:0]), 10);
      rd(2'b01, 2'b00);
      chk("ge_read", res0(), 100);
      chk("ge_err0", int'(read_err[0]), 0);
      rd(2'b01, 2'b00);
      chk("ge_err1", int'(read_err[0]), 1);

      // threshold <=, negative level
      trig_mode = 4'b0010; threshold = -16'sd50;
      pulse_arm(2'b01);
      for (int i = 0; i <= 8; i++) strobe(2'b01, -10 * i);
      chk("le_taddr", int'(trig_addr[AW-1:0]), 5);
      rd(2'b01, 2'b00);
      chk("le_read", res0(), -50);

      // async reset while in POST
      pre_count = 1; post_count = 3; trig_mode = 4'b0000;
      pulse_arm(2'b01);
      strobe(2'b01, 1); strobe(2'b01, 2);
      pulse_ext(2'b01);
      strobe(2'b01, 3); strobe(2'b01, 4);
      chk("post_taddr", int'(trig_addr[AW-1:0]), 2);
      chk("post_not_avail", int'(wave_available[0]), 0);
      @(negedge dsp_clk);
      #2 reset_n = 0;
      #1;
      chk("rst_avail", int'(wave_available), 0);
      chk("rst_taddr", int'(trig_addr), 0);
      repeat (2) @(negedge dsp_clk);
      reset_n = 1;
      repeat (3) @(negedge dsp_clk);
      chk_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
